// File: rtl/rgb_pattern_ctrl.sv
// Button-driven colour pattern source: debounced mode stepping plus registered
// R/G/B intensities. Define RGB_PATTERN_GAMMA_EN to apply (v*v + v) >> 8 per channel.
`timescale 1ns/1ps

module rgb_pattern_ctrl #(
    parameter int DEBOUNCE_CYCLES = 240_000,
    parameter int STEP_CYCLES     = 60_000
) (
    input  logic       iCLOCK,
    input  logic       iRESET,
    input  logic       iBUTTON_n,
    output logic [7:0] oR,
    output logic [7:0] oG,
    output logic [7:0] oB,
    output logic [1:0] oMODE,
    output logic       oUPDATE
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STEP_CYCLES);

    typedef enum logic [1:0] {
        RAINBOW = 2'd0,
        BREATHE = 2'd1,
        BLINK   = 2'd2,
        OFF     = 2'd3
    } mode_t;

    logic            r_sync1, r_sync2, r_stable, r_press;
    logic [DB_W-1:0] r_db_cnt;
    mode_t           r_mode, w_mode_next;
    logic [ST_W-1:0] r_step;
    logic [10:0]     r_phase;
    logic [7:0]      r_level;
    logic            r_dir_up;
    logic            r_evt;
    logic            w_tick;
    logic [7:0]      w_r, w_g, w_b;
    logic [2:0]      w_sector;
    logic [7:0]      w_frac;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_sync1  <= 1'b1;
            r_sync2  <= 1'b1;
            r_stable <= 1'b1;
            r_db_cnt <= '0;
            r_press  <= 1'b0;
        end else begin
            r_sync1 <= iBUTTON_n;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            if (r_sync2 == r_stable) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db_cnt <= '0;
                r_stable <= r_sync2;
                r_press  <= ~r_sync2;   // only the press (1->0) flip is an event
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge iCLOCK) begin
        if (iRESET) r_mode <= RAINBOW;
        else        r_mode <= w_mode_next;
    end

    // NOTE: combinational blocks assign a default first so no path leaves a latch.
    always_comb begin
        w_mode_next = r_mode;
        if (r_press) begin
            unique case (r_mode)
                RAINBOW: w_mode_next = BREATHE;
                BREATHE: w_mode_next = BLINK;
                BLINK:   w_mode_next = OFF;
                OFF:     w_mode_next = RAINBOW;
            endcase
        end
    end

    assign w_tick = (r_step == ST_W'(STEP_CYCLES - 1));

    // A press restarts the animation and suppresses any coincident step.
    always_ff @(posedge iCLOCK) begin
        if (iRESET || r_press) begin
            r_step   <= '0;
            r_phase  <= '0;
            r_level  <= '0;
            r_dir_up <= 1'b1;
        end else if (w_tick) begin
            r_step  <= '0;
            r_phase <= (r_phase == 11'd1535) ? 11'd0 : r_phase + 11'd1;
            if (r_dir_up) begin
                r_level <= r_level + 8'd1;
                if (r_level == 8'd254) r_dir_up <= 1'b0;
            end else begin
                r_level <= r_level - 8'd1;
                if (r_level == 8'd1) r_dir_up <= 1'b1;
            end
        end else begin
            r_step <= r_step + 1'b1;
        end
    end

    assign w_sector = r_phase[10:8];
    assign w_frac   = r_phase[7:0];

    always_comb begin
        w_r = 8'd0;
        w_g = 8'd0;
        w_b = 8'd0;
        unique case (r_mode)
            RAINBOW: begin
                case (w_sector)
                    3'd0:    begin w_r = 8'd255;          w_g = w_frac;          end
                    3'd1:    begin w_r = 8'd255 - w_frac; w_g = 8'd255;          end
                    3'd2:    begin w_g = 8'd255;          w_b = w_frac;          end
                    3'd3:    begin w_g = 8'd255 - w_frac; w_b = 8'd255;          end
                    3'd4:    begin w_r = w_frac;          w_b = 8'd255;          end
                    3'd5:    begin w_r = 8'd255;          w_b = 8'd255 - w_frac; end
                    default: begin w_r = 8'd255;                                 end
                endcase
            end
            BREATHE: begin
                w_r = r_level;
                w_g = r_level;
                w_b = r_level;
            end
            BLINK: begin
                w_r = r_phase[8] ? 8'd0 : 8'd255;
                w_g = w_r;
                w_b = w_r;
            end
            OFF: begin
                w_r = 8'd0;
            end
        endcase
    end

`ifdef RGB_PATTERN_GAMMA_EN
    function automatic logic [7:0] f_shape(input logic [7:0] v);
        logic [15:0] sq;
        sq = {8'd0, v} * {8'd0, v} + {8'd0, v};
        return sq[15:8];
    endfunction
`else
    function automatic logic [7:0] f_shape(input logic [7:0] v);
        return v;
    endfunction
`endif

    // Outputs trail the state by one cycle; r_evt delays the strobe to match.
    always_ff @(posedge iCLOCK) begin
        if (iRESET) begin
            r_evt   <= 1'b0;
            oR      <= 8'd255;
            oG      <= 8'd0;
            oB      <= 8'd0;
            oMODE   <= 2'd0;
            oUPDATE <= 1'b0;
        end else begin
            r_evt   <= w_tick | r_press;
            oR      <= f_shape(w_r);
            oG      <= f_shape(w_g);
            oB      <= f_shape(w_b);
            oMODE   <= r_mode;
            oUPDATE <= r_evt;
        end
    end

endmodule

// File: tb/tb_rgb_pattern_ctrl.sv
// Scoreboard bench for rgb_pattern_ctrl: expected updates are queued keyed by
// (mode, ticks since last mode change); a monitor compares on each oUPDATE.
`timescale 1ns/1ps

module tb_rgb_pattern_ctrl;

    localparam int DB = 16;
    localparam int ST = 4;

    logic       iCLOCK    = 1'b0;
    logic       iRESET    = 1'b1;
    logic       iBUTTON_n = 1'b1;
    logic [7:0] oR, oG, oB;
    logic [1:0] oMODE;
    logic       oUPDATE;

    always #5 iCLOCK = ~iCLOCK;

    rgb_pattern_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .STEP_CYCLES     (ST)
    ) dut (
        .iCLOCK    (iCLOCK),
        .iRESET    (iRESET),
        .iBUTTON_n (iBUTTON_n),
        .oR        (oR),
        .oG        (oG),
        .oB        (oB),
        .oMODE     (oMODE),
        .oUPDATE   (oUPDATE)
    );

    typedef struct {
        int mode;
        int tick;
        int r;
        int g;
        int b;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_errors  = 0;
    int   mon_ticks = 0;
    int   mon_mode  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    function automatic int gm(input int v);
`ifdef RGB_PATTERN_GAMMA_EN
        return (v * v + v) >> 8;
`else
        return v;
`endif
    endfunction

    function automatic void push(input int m, input int t, input int r, input int g, input int b);
        exp_t e;
        e = '{m, t, gm(r), gm(g), gm(b)};
        sb_q.push_back(e);
    endfunction

    // Monitor: count updates since the last observed mode change, compare on key match.
    always @(negedge iCLOCK) begin
        exp_t e;
        if (iRESET) begin
            mon_ticks = 0;
            mon_mode  = 0;
        end else if (oUPDATE) begin
            if (int'(oMODE) != mon_mode) begin
                mon_mode  = int'(oMODE);
                mon_ticks = 0;
            end else begin
                mon_ticks++;
            end
            if (sb_q.size() > 0 && sb_q[0].mode == mon_mode && sb_q[0].tick == mon_ticks) begin
                e = sb_q.pop_front();
                check($sformatf("m%0d t%0d R", e.mode, e.tick), 32'(oR), 32'(e.r));
                check($sformatf("m%0d t%0d G", e.mode, e.tick), 32'(oG), 32'(e.g));
                check($sformatf("m%0d t%0d B", e.mode, e.tick), 32'(oB), 32'(e.b));
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge iCLOCK);
    endtask

    task automatic press();
        iBUTTON_n = 1'b0;
        cycles(20);
        iBUTTON_n = 1'b1;
        cycles(25);
    endtask

    task automatic drain(input string tag, input int budget);
        int   k;
        exp_t e;
        k = 0;
        while (sb_q.size() > 0 && k < budget) begin
            @(negedge iCLOCK);
            k++;
        end
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: update m%0d t%0d never seen, expected %0d/%0d/%0d",
                     tag, e.mode, e.tick, e.r, e.g, e.b);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " oR"},      32'(oR),      32'd255);
        check({tag, " oG"},      32'(oG),      32'd0);
        check({tag, " oB"},      32'(oB),      32'd0);
        check({tag, " oMODE"},   32'(oMODE),   32'd0);
        check({tag, " oUPDATE"}, 32'(oUPDATE), 32'd0);
    endtask

    initial begin
        int k;

        // Reset held for three cycles.
        iRESET = 1'b1;
        cycles(3);
        check_reset_outputs("reset");

        // Rainbow sweep, including the 1535 -> 0 wrap.
        push(0, 1,    255, 1,   0);
        push(0, 320,  191, 255, 0);
        push(0, 1535, 255, 0,   0);
        push(0, 1536, 255, 0,   0);
        iRESET = 1'b0;
        drain("rainbow", 1536 * ST + 100);

        // Bounce rejection: short low bursts never reach the debounce count.
        iBUTTON_n = 1'b0; cycles(10);
        iBUTTON_n = 1'b1; cycles(3);
        iBUTTON_n = 1'b0; cycles(10);
        iBUTTON_n = 1'b1; cycles(30);
        check("bounce oMODE", 32'(oMODE), 32'd0);

        // Clean press into BREATHE, then the level triangle.
        push(1, 0,   0,   0,   0);
        push(1, 128, 128, 128, 128);
        push(1, 255, 255, 255, 255);
        push(1, 256, 254, 254, 254);
        push(1, 510, 0,   0,   0);
        push(1, 511, 1,   1,   1);
        press();
        drain("breathe", 512 * ST + 100);

        // Press timed to land on a step tick: the press wins, no step is taken.
        push(2, 0,   255, 255, 255);
        push(2, 255, 255, 255, 255);
        push(2, 256, 0,   0,   0);
        k = 0;
        while (!oUPDATE && k < 50) begin
            @(negedge iCLOCK);
            k++;
        end
        check("align to update", 32'(oUPDATE), 32'd1);
        iBUTTON_n = 1'b0;
        cycles(25);
        iBUTTON_n = 1'b1;
        drain("blink", 256 * ST + 100);

        // Remaining presses: OFF, then wrap back to RAINBOW.
        push(3, 0, 0, 0, 0);
        push(3, 1, 0, 0, 0);
        press();
        drain("off", 100);
        push(0, 0, 255, 0, 0);
        push(0, 1, 255, 1, 0);
        press();
        drain("wrap", 100);

        // Reset after 10 of 16 debounce cycles; a later short press must not complete it.
        iBUTTON_n = 1'b0;
        cycles(12);
        iRESET    = 1'b1;
        iBUTTON_n = 1'b1;
        cycles(1);
        check_reset_outputs("mid reset");
        cycles(1);
        push(0, 1, 255, 1, 0);
        iRESET    = 1'b0;
        iBUTTON_n = 1'b0;
        cycles(8);
        iBUTTON_n = 1'b1;
        cycles(40);
        check("mid-debounce oMODE", 32'(oMODE), 32'd0);
        drain("post reset", 100);

        // Button held through reset registers one press afterwards.
        iBUTTON_n = 1'b0;
        iRESET    = 1'b1;
        cycles(3);
        push(1, 0, 0, 0, 0);
        iRESET = 1'b0;
        drain("held press", 60);
        iBUTTON_n = 1'b1;
        cycles(30);
        check("held press oMODE", 32'(oMODE), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
